// File: rtl/hdmi_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_timing_ctrl
// Description : Programmable video timing generator for the HDMI output path.
//               Produces H/V sync, data-enable and the frame-buffer read strobe.
//               Active video is gated on read-FIFO readiness. FIFO underflow is
//               flagged and the controller falls back to blanked frames until
//               the FIFO is ready at a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_timing_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CNT_W    = 12
) (
    input  logic             Pixl_CLK,
    input  logic             Rst_Posedge,
    input  logic             I_Enable,
    input  logic             I_Fifo_Ready,
    input  logic             I_Fifo_Empty,
    input  logic             I_Clr_Err,
    output logic             O_H_Sync,
    output logic             O_V_Sync,
    output logic             O_VGA_De,
    output logic             O_Rd_En,
    output logic             O_Frame_Start,
    output logic             O_Line_Start,
    output logic [CNT_W-1:0] O_H_Cnt,
    output logic [CNT_W-1:0] O_V_Cnt,
    output logic             O_Underflow,
    output logic [1:0]       O_State
);

    // Timing landmarks expressed at counter width
    localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_hs_beg   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_vs_beg   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic             c_hs_on    = 1'(HS_POL);
    localparam logic             c_vs_on    = 1'(VS_POL);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic             r_fs;
    logic             r_ls;
    logic             r_uf;
    logic             r_frame_err;

    logic             w_frame_end;
    logic             w_uf_trig;
    logic [1:0]       w_state_nxt;
    logic             w_active_nxt;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;

    // The registered outputs describe position (r_h, r_v); all decisions look at it
    assign w_frame_end = (r_h == c_h_last) && (r_v == c_v_last);
    assign w_uf_trig   = r_de && I_Fifo_Empty;

    // Next-state decision: only IDLE reacts immediately, ARM/RUN change at frame end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (I_Enable) w_state_nxt = c_st_arm;
            end
            c_st_arm: begin
                if (w_frame_end) begin
                    if (!I_Enable)        w_state_nxt = c_st_idle;
                    else if (I_Fifo_Ready) w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_frame_end) begin
                    if (!I_Enable)
                        w_state_nxt = c_st_idle;
                    else if (r_frame_err || w_uf_trig || !I_Fifo_Ready)
                        w_state_nxt = c_st_arm;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Next position: held at origin in IDLE and on the cycle that leaves IDLE
    always_comb begin
        w_active_nxt = (w_state_nxt != c_st_idle);
        w_h_nxt      = '0;
        w_v_nxt      = '0;
        if ((r_state != c_st_idle) && w_active_nxt) begin
            if (r_h == c_h_last) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == c_v_last) ? '0 : r_v + c_cnt_one;
            end else begin
                w_h_nxt = r_h + c_cnt_one;
                w_v_nxt = r_v;
            end
        end
    end

    // Position, state and every output registered together so they stay aligned
    always_ff @(posedge Pixl_CLK) begin
        if (Rst_Posedge) begin
            r_state <= c_st_idle;
            r_h     <= '0;
            r_v     <= '0;
            r_hs    <= ~c_hs_on;
            r_vs    <= ~c_vs_on;
            r_de    <= 1'b0;
            r_fs    <= 1'b0;
            r_ls    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_hs    <= (w_active_nxt && (w_h_nxt >= c_hs_beg) && (w_h_nxt < c_hs_end))
                       ? c_hs_on : ~c_hs_on;
            r_vs    <= (w_active_nxt && (w_v_nxt >= c_vs_beg) && (w_v_nxt < c_vs_end))
                       ? c_vs_on : ~c_vs_on;
            r_de    <= (w_state_nxt == c_st_run) && (w_h_nxt < c_h_act) && (w_v_nxt < c_v_act);
            r_fs    <= w_active_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
            r_ls    <= w_active_nxt && (w_h_nxt == '0);
        end
    end

    // Sticky underflow flag (a new underflow beats a simultaneous clear) and per-frame error
    always_ff @(posedge Pixl_CLK) begin
        if (Rst_Posedge) begin
            r_uf        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_uf_trig)      r_uf <= 1'b1;
            else if (I_Clr_Err) r_uf <= 1'b0;

            if (w_frame_end)    r_frame_err <= 1'b0;
            else if (w_uf_trig) r_frame_err <= 1'b1;
        end
    end

    assign O_H_Sync      = r_hs;
    assign O_V_Sync      = r_vs;
    assign O_VGA_De      = r_de;
    assign O_Rd_En       = r_de;
    assign O_Frame_Start = r_fs;
    assign O_Line_Start  = r_ls;
    assign O_H_Cnt       = r_h;
    assign O_V_Cnt       = r_v;
    assign O_Underflow   = r_uf;
    assign O_State       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_timing_ctrl
// Description : Scoreboard bench for hdmi_timing_ctrl with a reduced raster
//               (H 8/2/2/2 -> 14 pixels, V 4/1/1/1 -> 7 lines, 98 cycles/frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_timing_ctrl;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_arm  = 2'd1;
    localparam logic [1:0] c_run  = 2'd2;

    typedef struct packed {
        logic [1:0]  st;
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        rd;
        logic        fs;
        logic        ls;
        logic        uf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rdy;
    logic        emp;
    logic        clr;
    logic        o_hs, o_vs, o_de, o_rd, o_fs, o_ls, o_uf;
    logic [11:0] o_h, o_v;
    logic [1:0]  o_st;

    exp_t q_exp[$];
    int   q_tag[$];
    int   vectors;
    int   miscompares;
    int   scen;
    logic uf_m;

    hdmi_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CNT_W(12)
    ) dut (
        .Pixl_CLK      (clk),
        .Rst_Posedge   (rst),
        .I_Enable      (en),
        .I_Fifo_Ready  (rdy),
        .I_Fifo_Empty  (emp),
        .I_Clr_Err     (clr),
        .O_H_Sync      (o_hs),
        .O_V_Sync      (o_vs),
        .O_VGA_De      (o_de),
        .O_Rd_En       (o_rd),
        .O_Frame_Start (o_fs),
        .O_Line_Start  (o_ls),
        .O_H_Cnt       (o_h),
        .O_V_Cnt       (o_v),
        .O_Underflow   (o_uf),
        .O_State       (o_st)
    );

    // Free-running pixel clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs for a displayed position, from the hand-derived raster:
    // h-sync at h=10,11; v-sync on line 5; DE for h<8, v<4 in RUN only
    function automatic exp_t mk(input logic [1:0] st, input int h, input int v, input logic uf);
        exp_t e;
        logic act;
        act  = (st != c_idle);
        e.st = st;
        e.h  = 12'(h);
        e.v  = 12'(v);
        e.hs = act && (h == 10 || h == 11);
        e.vs = act && (v == 5);
        e.de = (st == c_run) && (h < 8) && (v < 4);
        e.rd = e.de;
        e.fs = act && (h == 0) && (v == 0);
        e.ls = act && (h == 0);
        e.uf = uf;
        return e;
    endfunction

    // One clock: inputs already set, queue the response expected after the edge
    task automatic tick(input exp_t e, input int k);
        q_exp.push_back(e);
        q_tag.push_back(scen * 1000 + k);
        @(posedge clk);
        #2;
    endtask

    // Output positions k0..k1-1 of a frame in state st; emp/clr pulsed on the given ticks
    task automatic frame(input logic [1:0] st, input int k0, input int k1,
                         input int emp_k, input int clr_k);
        for (int k = k0; k < k1; k++) begin
            emp = (k == emp_k);
            clr = (k == clr_k);
            if (k == emp_k)      uf_m = 1'b1;
            else if (k == clr_k) uf_m = 1'b0;
            tick(mk(st, k % 14, k / 14, uf_m), k);
        end
        emp = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(mk(c_idle, 0, 0, uf_m), 900 + i);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    initial begin
        exp_t e;
        exp_t got;
        int   tag;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e   = q_exp.pop_front();
                tag = q_tag.pop_front();
                got = '{st: o_st, h: o_h, v: o_v, hs: o_hs, vs: o_vs, de: o_de,
                        rd: o_rd, fs: o_fs, ls: o_ls, uf: o_uf};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs scen=%0d k=%0d got st=%0d h=%0d v=%0d hs=%b vs=%b de=%b rd=%b fs=%b ls=%b uf=%b required st=%0d h=%0d v=%0d hs=%b vs=%b de=%b rd=%b fs=%b ls=%b uf=%b",
                             tag / 1000, tag % 1000,
                             got.st, got.h, got.v, got.hs, got.vs, got.de, got.rd, got.fs, got.ls, got.uf,
                             e.st, e.h, e.v, e.hs, e.vs, e.de, e.rd, e.fs, e.ls, e.uf);
                end
            end
        end
    end

    // Stimulus
    initial begin
        vectors     = 0;
        miscompares = 0;
        uf_m        = 1'b0;
        rst = 1'b1; en = 1'b0; rdy = 1'b0; emp = 1'b0; clr = 1'b0;

        // 1: reset for 3 cycles, then enable with FIFO ready -> one ARM frame, then RUN
        scen = 1;
        for (int i = 0; i < 3; i++) tick(mk(c_idle, 0, 0, 1'b0), i);
        rst = 1'b0; en = 1'b1; rdy = 1'b1;
        frame(c_arm, 0, 98, -1, -1);
        frame(c_run, 0, 98, -1, -1);

        // 2: another full RUN frame (syncs, line/frame pulses)
        scen = 2;
        frame(c_run, 0, 98, -1, -1);

        // 4: underflow while FIFO empty at displayed (3,1); next frame ARM; clear the flag
        scen = 4;
        frame(c_run, 0, 98, 18, -1);
        frame(c_arm, 0, 98, -1, 50);
        frame(c_run, 0, 98, -1, -1);

        // 5: drop enable at displayed (5,2); frame completes, then IDLE
        scen = 5;
        frame(c_run, 0, 34, -1, -1);
        en = 1'b0;
        frame(c_run, 34, 98, -1, -1);
        idle_ticks(5);

        // 3: enable without FIFO ready -> ARM for 3 frames; ready mid-frame -> RUN next frame
        scen = 3;
        en = 1'b1; rdy = 1'b0;
        frame(c_arm, 0, 98, -1, -1);
        frame(c_arm, 0, 98, -1, -1);
        frame(c_arm, 0, 40, -1, -1);
        rdy = 1'b1;
        frame(c_arm, 40, 98, -1, -1);
        frame(c_run, 0, 98, -1, -1);

        // 6: underflow coinciding with a clear (set wins), then reset at displayed (4,1)
        scen = 6;
        frame(c_run, 0, 19, 5, 5);
        rst  = 1'b1;
        uf_m = 1'b0;
        tick(mk(c_idle, 0, 0, 1'b0), 19);
        rst = 1'b0; en = 1'b0;
        idle_ticks(3);

        #5;
        if (q_exp.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d entries left required 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
